// File: rtl/mem_stage_responder_pkg.sv
// Shared types for the memory stage: M/W result record, FSM state codes, widths
// and the address legality helper.
package mem_stage_responder_pkg;

    localparam int DATA_W = 32;
    localparam int REG_W  = 5;

    typedef logic [1:0] mem_state_t;
    localparam mem_state_t ST_IDLE = 2'd0;
    localparam mem_state_t ST_BUSY = 2'd1;
    localparam mem_state_t ST_RESP = 2'd2;

    typedef struct packed {
        logic [DATA_W-1:0] val;
        logic [REG_W-1:0]  dst;
        logic              wr_en;
        logic              valid;
    } mw_data_t;

    // Word accesses only; anything at or beyond 4*DEPTH bytes is outside the array.
    function automatic logic addr_illegal(input logic [31:0] addr, input int idx_w);
        return (addr[1:0] != 2'b00) || ((addr >> (idx_w + 2)) != 32'd0);
    endfunction

endpackage

// File: rtl/mem_stage_responder_mem.sv
// Single-port synchronous data RAM: one write or read per cycle, read data
// registered on the same edge. Contents are never reset.
module data_mem_array #(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 256,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              we_i,
    input  logic              re_i,
    input  logic [AW-1:0]     addr_i,
    input  logic [DATA_W-1:0] wdata_i,
    output logic [DATA_W-1:0] rdata_o
);

    logic [DATA_W-1:0] mem_q [DEPTH];

    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[addr_i] <= wdata_i;
        end
        if (re_i) begin
            rdata_o <= mem_q[addr_i];
        end
    end

endmodule

// File: rtl/mem_stage_responder.sv
// Memory stage: serves loads/stores with LATENCY cycles of upstream stall, passes
// other ops straight through, and presents a registered M/W result.
module mem_stage_responder #(
    parameter int DATA_W  = mem_stage_responder_pkg::DATA_W,
    parameter int DEPTH   = 256,
    parameter int LATENCY = 3,
    parameter int REG_W   = mem_stage_responder_pkg::REG_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              m_read,
    input  logic              m_write,
    input  logic [31:0]       m_addr,
    input  logic [DATA_W-1:0] m_val,
    input  logic [REG_W-1:0]  m_dst,
    output logic              mem_stall,
    output logic              mw_valid,
    output logic [DATA_W-1:0] mw_val,
    output logic [REG_W-1:0]  mw_dst,
    output logic              mw_wr_en,
    output logic              mem_err
);
    import mem_stage_responder_pkg::*;

    localparam int         IDX_W    = $clog2(DEPTH);
    localparam logic [3:0] CNT_LOAD = 4'(LATENCY - 1);

    mem_state_t        state_q, state_d;
    logic [3:0]        cnt_q, cnt_d;
    logic              req_store_q, req_store_d, req_bad_q, req_bad_d, req_err_q, req_err_d;
    logic [IDX_W-1:0]  req_idx_q, req_idx_d;
    logic [DATA_W-1:0] req_val_q, req_val_d;
    logic [REG_W-1:0]  req_dst_q, req_dst_d;
    mw_data_t          mw_q, mw_d;
    logic              load_rsp_q, load_rsp_d, err_q, err_d;

    logic              busy, cap, go_resp;
    logic              acc_store, acc_bad, acc_err;
    logic [IDX_W-1:0]  acc_idx;
    logic [DATA_W-1:0] acc_val, ram_rdata;
    logic [REG_W-1:0]  acc_dst;

    // The access that completes this cycle: held request while BUSY, the live
    // request otherwise (single-cycle latency completes on the capture edge).
    always_comb begin
        busy = (state_q == ST_BUSY);
        cap  = !reset && !busy && (m_read || m_write);
        if (busy) begin
            acc_store = req_store_q;
            acc_bad   = req_bad_q;
            acc_err   = req_err_q;
            acc_idx   = req_idx_q;
            acc_val   = req_val_q;
            acc_dst   = req_dst_q;
        end else begin
            acc_store = m_write;
            acc_bad   = addr_illegal(m_addr, IDX_W);
            acc_err   = addr_illegal(m_addr, IDX_W) || (m_read && m_write);
            acc_idx   = m_addr[IDX_W+1:2];
            acc_val   = m_val;
            acc_dst   = m_dst;
        end
        go_resp = !reset && ((cap && (LATENCY == 1)) || (busy && (cnt_q == 4'd1)));
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        req_store_d = req_store_q;
        req_bad_d   = req_bad_q;
        req_err_d   = req_err_q;
        req_idx_d   = req_idx_q;
        req_val_d   = req_val_q;
        req_dst_d   = req_dst_q;
        mw_d        = '0;
        load_rsp_d  = 1'b0;
        err_d       = 1'b0;
        if (busy) begin
            cnt_d = cnt_q - 4'd1;
            if (cnt_q == 4'd1) begin
                state_d = ST_RESP;
            end
        end else if (m_read || m_write) begin
            req_store_d = acc_store;
            req_bad_d   = acc_bad;
            req_err_d   = acc_err;
            req_idx_d   = acc_idx;
            req_val_d   = acc_val;
            req_dst_d   = acc_dst;
            cnt_d       = CNT_LOAD;
            state_d     = (LATENCY == 1) ? ST_RESP : ST_BUSY;
        end else begin
            state_d    = ST_IDLE;
            mw_d.val   = m_val;
            mw_d.dst   = m_dst;
            mw_d.wr_en = (m_dst != '0);
            mw_d.valid = 1'b1;
        end
        if (go_resp) begin
            mw_d.valid = 1'b1;
            if (!acc_store) begin
                mw_d.dst   = acc_dst;
                mw_d.wr_en = !acc_bad && (acc_dst != '0);
            end
            load_rsp_d = !acc_store && !acc_bad;
            err_d      = acc_err;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            req_store_q <= 1'b0;
            req_bad_q   <= 1'b0;
            req_err_q   <= 1'b0;
            req_idx_q   <= '0;
            req_val_q   <= '0;
            req_dst_q   <= '0;
            mw_q        <= '0;
            load_rsp_q  <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            req_store_q <= req_store_d;
            req_bad_q   <= req_bad_d;
            req_err_q   <= req_err_d;
            req_idx_q   <= req_idx_d;
            req_val_q   <= req_val_d;
            req_dst_q   <= req_dst_d;
            mw_q        <= mw_d;
            load_rsp_q  <= load_rsp_d;
            err_q       <= err_d;
        end
    end

    data_mem_array #(.DATA_W(DATA_W), .DEPTH(DEPTH)) u_mem (
        .clk     (clk),
        .we_i    (go_resp && acc_store && !acc_bad),
        .re_i    (go_resp && !acc_store && !acc_bad),
        .addr_i  (acc_idx),
        .wdata_i (acc_val),
        .rdata_o (ram_rdata)
    );

    assign mem_stall = !reset && (busy || cap);
    assign mw_valid  = mw_q.valid;
    assign mw_val    = load_rsp_q ? ram_rdata : mw_q.val;
    assign mw_dst    = mw_q.dst;
    assign mw_wr_en  = mw_q.wr_en;
    assign mem_err   = err_q;

endmodule

// File: tb/tb_mem_stage_responder.sv
// Bench for mem_stage_responder: instance 0 has LATENCY=3, instance 1 LATENCY=1.
// A request's result is visible in the first cycle the following request is presented.
module tb_mem_stage_responder;

    typedef struct packed {
        logic        valid;
        logic [31:0] val;
        logic [4:0]  dst;
        logic        wr_en;
        logic        err;
    } resp_t;

    typedef struct {
        int          d;
        logic        rd;
        logic        wr;
        logic [31:0] addr;
        logic [31:0] val;
        logic [4:0]  dst;
        int          stalls;
        resp_t       exp;
        string       name;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst       [2];
    logic        m_read    [2];
    logic        m_write   [2];
    logic [31:0] m_addr    [2];
    logic [31:0] m_val     [2];
    logic [4:0]  m_dst     [2];
    logic        mem_stall [2];
    logic        mw_valid  [2];
    logic [31:0] mw_val    [2];
    logic [4:0]  mw_dst    [2];
    logic        mw_wr_en  [2];
    logic        mem_err   [2];

    always #5 clk = ~clk;

    for (genvar g = 0; g < 2; g++) begin : g_dut
        mem_stage_responder #(.DATA_W(32), .DEPTH(256), .LATENCY(g == 0 ? 3 : 1), .REG_W(5)) u_dut (
            .clk       (clk),
            .reset     (rst[g]),
            .m_read    (m_read[g]),
            .m_write   (m_write[g]),
            .m_addr    (m_addr[g]),
            .m_val     (m_val[g]),
            .m_dst     (m_dst[g]),
            .mem_stall (mem_stall[g]),
            .mw_valid  (mw_valid[g]),
            .mw_val    (mw_val[g]),
            .mw_dst    (mw_dst[g]),
            .mw_wr_en  (mw_wr_en[g]),
            .mem_err   (mem_err[g])
        );
    end

    int          n_vec = 0;
    int          n_bad = 0;
    resp_t       prev [2];
    logic [31:0] ref_mem [2][256];
    vec_t        tbl [$];

    function automatic int lat_of(input int d);
        return (d == 0) ? 3 : 1;
    endfunction

    task automatic check(input int d, input string name, input logic exp_stall, input resp_t exp);
        logic [40:0] act, want;
        act  = {mem_stall[d], mw_valid[d], mw_val[d], mw_dst[d], mw_wr_en[d], mem_err[d]};
        want = {exp_stall, exp};
        n_vec++;
        if (act !== want) begin
            n_bad++;
            $display("FAIL %s dut%0d: got stall=%b valid=%b val=%h dst=%0d wr_en=%b err=%b, want stall=%b valid=%b val=%h dst=%0d wr_en=%b err=%b",
                     name, d, mem_stall[d], mw_valid[d], mw_val[d], mw_dst[d], mw_wr_en[d], mem_err[d],
                     exp_stall, exp.valid, exp.val, exp.dst, exp.wr_en, exp.err);
        end
    endtask

    task automatic set_idle(input int d);
        m_read[d]  = 1'b0;
        m_write[d] = 1'b0;
        m_addr[d]  = '0;
        m_val[d]   = '0;
        m_dst[d]   = '0;
    endtask

    // Ends at posedge+1 with reset released and the DUT in its reset state.
    task automatic do_reset(input int d);
        set_idle(d);
        rst[d] = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check(d, "reset_state", 1'b0, '0);
        @(posedge clk);
        #1 rst[d] = 1'b0;
        prev[d] = '0;
    endtask

    // Called and returns at posedge+1. Holds the request for its stall cycles.
    task automatic run_op(input int d, input logic rd, input logic wr, input logic [31:0] addr,
                          input logic [31:0] val, input logic [4:0] dst, input int stalls,
                          input resp_t exp, input string name);
        m_read[d]  = rd;
        m_write[d] = wr;
        m_addr[d]  = addr;
        m_val[d]   = val;
        m_dst[d]   = dst;
        @(negedge clk);
        check(d, {name, "_first"}, stalls > 0, prev[d]);
        for (int k = 1; k < stalls; k++) begin
            @(posedge clk);
            #1;
            @(negedge clk);
            check(d, {name, "_stall"}, 1'b1, '0);
        end
        @(posedge clk);
        #1;
        prev[d] = exp;
    endtask

    // Reference behaviour straight from the rules: word array, legality test, result record.
    task automatic model(input int d, input logic rd, input logic wr, input logic [31:0] addr,
                         input logic [31:0] val, input logic [4:0] dst, output resp_t r);
        logic bad;
        bad = (addr[1:0] != 2'b00) || (addr >= 32'd1024);
        r = '0;
        r.valid = 1'b1;
        if (!rd && !wr) begin
            r.val   = val;
            r.dst   = dst;
            r.wr_en = (dst != 5'd0);
        end else if (wr) begin
            r.err = bad || rd;
            if (!bad) ref_mem[d][addr[9:2]] = val;
        end else begin
            r.dst = dst;
            r.err = bad;
            if (!bad) begin
                r.val   = ref_mem[d][addr[9:2]];
                r.wr_en = (dst != 5'd0);
            end
        end
    endtask

    task automatic add(input int d, input logic rd, input logic wr, input logic [31:0] addr,
                       input logic [31:0] val, input logic [4:0] dst, input int stalls,
                       input logic ev, input logic [31:0] eval, input logic [4:0] edst,
                       input logic ewr, input logic eerr, input string name);
        vec_t v;
        v.d = d; v.rd = rd; v.wr = wr; v.addr = addr; v.val = val; v.dst = dst;
        v.stalls = stalls; v.name = name;
        v.exp.valid = ev; v.exp.val = eval; v.exp.dst = edst; v.exp.wr_en = ewr; v.exp.err = eerr;
        tbl.push_back(v);
    endtask

    task automatic rand_phase(input int d, input int n);
        resp_t       r;
        logic        rd, wr;
        logic [31:0] addr, val;
        logic [4:0]  dst;
        int          sel;
        for (int i = 0; i < 16; i++) begin
            addr = 32'h100 + 32'(i * 4);
            val  = $urandom;
            model(d, 1'b0, 1'b1, addr, val, 5'd0, r);
            run_op(d, 1'b0, 1'b1, addr, val, 5'd0, lat_of(d), r, "pre_store");
        end
        for (int i = 0; i < n; i++) begin
            sel = $urandom_range(0, 9);
            rd  = (sel >= 3) && (sel <= 6);
            wr  = (sel >= 7);
            val = $urandom;
            dst = 5'($urandom_range(0, 31));
            sel = $urandom_range(0, 19);
            if (sel < 16)      addr = 32'h100 + 32'($urandom_range(0, 15) * 4);
            else if (sel < 18) addr = 32'h100 + 32'($urandom_range(0, 15) * 4 + $urandom_range(1, 3));
            else if (sel < 19) addr = 32'h400 + 32'($urandom_range(0, 255) * 4);
            else               addr = $urandom | 32'h8000_0000;
            model(d, rd, wr, addr, val, dst, r);
            run_op(d, rd, wr, addr, val, dst, (rd || wr) ? lat_of(d) : 0, r, "rand");
        end
        run_op(d, 1'b0, 1'b0, '0, '0, '0, 0, resp_t'{1'b1, 32'h0, 5'd0, 1'b0, 1'b0}, "rand_idle");
    endtask

    initial begin
        logic d1_up;
        d1_up = 1'b0;
        for (int d = 0; d < 2; d++) begin
            rst[d] = 1'b1;
            set_idle(d);
        end

        add(0, 0, 0, 32'h0,   32'h1234,     5'd7, 0, 1, 32'h1234,     5'd7, 1, 0, "passthru");
        add(0, 0, 1, 32'h10,  32'hDEADBEEF, 5'd3, 3, 1, 32'h0,        5'd0, 0, 0, "st_10");
        add(0, 1, 0, 32'h10,  32'h5,        5'd4, 3, 1, 32'hDEADBEEF, 5'd4, 1, 0, "ld_10");
        add(0, 0, 1, 32'h20,  32'hCAFEF00D, 5'd0, 3, 1, 32'h0,        5'd0, 0, 0, "st_20");
        add(0, 1, 0, 32'h20,  32'h0,        5'd9, 3, 1, 32'hCAFEF00D, 5'd9, 1, 0, "ld_20_b2b");
        add(0, 0, 1, 32'h0,   32'h11111111, 5'd0, 3, 1, 32'h0,        5'd0, 0, 0, "st_00");
        add(0, 1, 0, 32'h13,  32'h0,        5'd5, 3, 1, 32'h0,        5'd5, 0, 1, "ld_misalign");
        add(0, 0, 1, 32'h400, 32'h99,       5'd0, 3, 1, 32'h0,        5'd0, 0, 1, "st_oor");
        add(0, 1, 0, 32'h0,   32'h0,        5'd6, 3, 1, 32'h11111111, 5'd6, 1, 0, "ld_00");
        add(0, 0, 1, 32'h30,  32'h5555AAAA, 5'd0, 3, 1, 32'h0,        5'd0, 0, 0, "st_30");
        add(0, 0, 0, 32'h0,   32'hFFFF0000, 5'd0, 0, 1, 32'hFFFF0000, 5'd0, 0, 0, "pass_dst0");
        add(0, 0, 0, 32'h0,   32'h0,        5'd0, 0, 1, 32'h0,        5'd0, 0, 0, "idle0");
        add(1, 0, 1, 32'h8,   32'h77,       5'd0, 1, 1, 32'h0,        5'd0, 0, 0, "l1_st_08");
        add(1, 1, 0, 32'h8,   32'h0,        5'd0, 1, 1, 32'h77,       5'd0, 0, 0, "l1_ld_dst0");
        add(1, 0, 0, 32'h0,   32'hABCD,     5'd31,0, 1, 32'hABCD,     5'd31,1, 0, "l1_pass");
        add(1, 0, 1, 32'h3FC, 32'h0BADF00D, 5'd0, 1, 1, 32'h0,        5'd0, 0, 0, "l1_st_3fc");
        add(1, 1, 0, 32'h3FC, 32'h0,        5'd1, 1, 1, 32'h0BADF00D, 5'd1, 1, 0, "l1_ld_3fc");
        add(1, 1, 0, 32'h400, 32'h0,        5'd2, 1, 1, 32'h0,        5'd2, 0, 1, "l1_ld_oor");
        add(1, 0, 0, 32'h0,   32'h0,        5'd0, 0, 1, 32'h0,        5'd0, 0, 0, "l1_idle");

        do_reset(0);
        foreach (tbl[i]) begin
            if (tbl[i].d == 1 && !d1_up) begin
                do_reset(1);
                d1_up = 1'b1;
            end
            run_op(tbl[i].d, tbl[i].rd, tbl[i].wr, tbl[i].addr, tbl[i].val, tbl[i].dst,
                   tbl[i].stalls, tbl[i].exp, tbl[i].name);
        end

        // Store aborted by reset in its second stall cycle; 0x30 must keep its old word.
        m_read[0]  = 1'b0;
        m_write[0] = 1'b1;
        m_addr[0]  = 32'h30;
        m_val[0]   = 32'hAA;
        m_dst[0]   = 5'd0;
        @(negedge clk);
        check(0, "rst_busy_cap", 1'b1, prev[0]);
        @(posedge clk);
        #1;
        @(negedge clk);
        check(0, "rst_busy_stall2", 1'b1, '0);
        #1 rst[0] = 1'b1;
        #1 check(0, "rst_busy_async", 1'b0, '0);
        set_idle(0);
        repeat (2) @(posedge clk);
        #1 rst[0] = 1'b0;
        prev[0] = '0;
        run_op(0, 1'b1, 1'b0, 32'h30, 32'h0, 5'd8, 3, resp_t'{1'b1, 32'h5555AAAA, 5'd8, 1'b1, 1'b0}, "ld_30_after_rst");
        run_op(0, 1'b0, 1'b0, '0, '0, '0, 0, resp_t'{1'b1, 32'h0, 5'd0, 1'b0, 1'b0}, "idle_after_rst");

        rand_phase(0, 150);
        rand_phase(1, 150);

        run_op(0, 1'b1, 1'b1, 32'h44, 32'h5A5A, 5'd3, 3, resp_t'{1'b1, 32'h0, 5'd0, 1'b0, 1'b1}, "rd_wr_both");
        run_op(0, 1'b0, 1'b0, '0, '0, '0, 0, resp_t'{1'b1, 32'h0, 5'd0, 1'b0, 1'b0}, "final_idle");
        run_op(0, 1'b0, 1'b0, '0, '0, '0, 0, resp_t'{1'b1, 32'h0, 5'd0, 1'b0, 1'b0}, "final_idle2");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
